// File: rtl/flash_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flash_writer_pkg
// Purpose  : Shared definitions for the AHB flash SPI/QSPI writer. Holds the
//            register offsets, the write-enable key, the CTRL/STATUS bit
//            indices, the shift-engine state encoding and lane helpers.
// Ports    : none (package)
// Macros   : none
// Revision : 1.0 - initial release
// ============================================================================
package flash_writer_pkg;

  // Register offsets (HADDR[7:0])
  localparam logic [7:0] C_ADDR_WE     = 8'h00;
  localparam logic [7:0] C_ADDR_CTRL   = 8'h04;
  localparam logic [7:0] C_ADDR_DIV    = 8'h08;
  localparam logic [7:0] C_ADDR_DATA   = 8'h0C;
  localparam logic [7:0] C_ADDR_STATUS = 8'h10;
  localparam logic [7:0] C_ADDR_IRQ_EN = 8'h14;

  // Upper 24 bits a WE write must carry to be honoured
  localparam logic [23:0] C_WE_KEY = 24'hA5A855;

  // CTRL bit indices
  localparam int C_CTRL_SS   = 0;
  localparam int C_CTRL_QUAD = 1;
  localparam int C_CTRL_RX   = 2;

  // STATUS bit indices
  localparam int C_ST_BUSY = 0;
  localparam int C_ST_DONE = 1;
  localparam int C_ST_OVR  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } eng_state_t;

  // Data driven on the lanes for the beat at the top of the shift register.
  function automatic logic [3:0] lane_dout(input logic [7:0] sh,
                                           input logic       quad,
                                           input logic       rx);
    if (quad) return rx ? 4'h0 : sh[7:4];
    return {3'b000, sh[7]};
  endfunction

  // Per-lane output enable for a transfer mode.
  function automatic logic [3:0] lane_oe(input logic quad, input logic rx);
    if (!quad) return 4'b0001;
    return rx ? 4'b0000 : 4'b1111;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flash_writer_shift.sv
`default_nettype none
// ============================================================================
// Module   : flash_shift_engine
// Purpose  : One-byte SPI/QSPI shift engine with programmable SCK half-period.
//            Mode (quad/rx) and divider are latched at start. MSB first.
// Ports    : HCLK, HRESETn        clock, async active-low reset
//            i_start, i_byte      start a transfer with this tx byte
//            i_quad, i_rx, i_div  mode and SCK half-period (div+1 cycles)
//            i_abort              drop to IDLE next cycle, no done, rx kept
//            i_din                flash data in
//            o_busy, o_done       transfer active / finish strobe
//            o_rx_byte            last fully received byte
//            o_sck, o_dout, o_douten  registered pin drive
// Macros   : none
// Revision : 1.0 - initial release
// ============================================================================
module flash_shift_engine
  import flash_writer_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             i_start,
  input  logic [7:0]       i_byte,
  input  logic             i_quad,
  input  logic             i_rx,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_abort,
  input  logic [3:0]       i_din,
  output logic             o_busy,
  output logic             o_done,
  output logic [7:0]       o_rx_byte,
  output logic             o_sck,
  output logic [3:0]       o_dout,
  output logic [3:0]       o_douten
);

  eng_state_t       r_state;
  logic             r_quad, r_rx, r_sck;
  logic [DIV_W-1:0] r_div, r_cnt;
  logic [2:0]       r_beat;
  logic [7:0]       r_tx_sh, r_rx_sh, r_rx_byte;
  logic [3:0]       r_dout, r_douten;

  logic       w_cnt_zero, w_last_beat;
  logic [7:0] w_tx_next, w_rx_next;

  assign w_cnt_zero  = (r_cnt == '0);
  assign w_last_beat = (r_beat == (r_quad ? 3'd1 : 3'd7));
  assign w_tx_next   = r_quad ? {r_tx_sh[3:0], 4'h0} : {r_tx_sh[6:0], 1'b0};
  // Single mode reads MISO on lane 1; quad reads all four lanes.
  assign w_rx_next   = r_quad ? {r_rx_sh[3:0], i_din} : {r_rx_sh[6:0], i_din[1]};

  // Finish strobe is combinational so the top's sticky DONE lands on the
  // same edge that returns the engine to IDLE.
  assign o_done    = (r_state == ST_HI) && w_cnt_zero && w_last_beat && !i_abort;
  assign o_busy    = (r_state != ST_IDLE);
  assign o_rx_byte = r_rx_byte;
  assign o_sck     = r_sck;
  assign o_dout    = r_dout;
  assign o_douten  = r_douten;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= ST_IDLE;
      r_quad    <= 1'b0;
      r_rx      <= 1'b0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_beat    <= 3'd0;
      r_tx_sh   <= 8'h00;
      r_rx_sh   <= 8'h00;
      r_rx_byte <= 8'h00;
      r_sck     <= 1'b0;
      r_dout    <= 4'h0;
      r_douten  <= 4'h0;
    end else if (i_abort) begin
      r_state  <= ST_IDLE;
      r_sck    <= 1'b0;
      r_dout   <= 4'h0;
      r_douten <= 4'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_quad   <= i_quad;
            r_rx     <= i_rx;
            r_div    <= i_div;
            r_cnt    <= i_div;
            r_beat   <= 3'd0;
            r_tx_sh  <= i_byte;
            r_sck    <= 1'b0;
            r_dout   <= lane_dout(i_byte, i_quad, i_rx);
            r_douten <= lane_oe(i_quad, i_rx);
            r_state  <= ST_LO;
          end
        end
        ST_LO: begin
          if (w_cnt_zero) begin
            r_state <= ST_HI;
            r_sck   <= 1'b1;
            r_cnt   <= r_div;
            r_rx_sh <= w_rx_next;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_HI: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_last_beat) begin
            r_state   <= ST_IDLE;
            r_sck     <= 1'b0;
            r_dout    <= 4'h0;
            r_douten  <= 4'h0;
            r_rx_byte <= r_rx_sh;
          end else begin
            r_state <= ST_LO;
            r_sck   <= 1'b0;
            r_cnt   <= r_div;
            r_beat  <= r_beat + 3'd1;
            r_tx_sh <= w_tx_next;
            r_dout  <= lane_dout(w_tx_next, r_quad, r_rx);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_flash_spi_writer.sv
`default_nettype none
// ============================================================================
// Module   : ahb_flash_spi_writer
// Purpose  : AHB-Lite slave that takes over the flash pins while WE=1 and
//            drives them from a hardware byte-shift engine; while WE=0 the
//            flash reader's pins pass straight through.
// Ports    : HCLK, HRESETn                 clock, async active-low reset
//            HSEL..HWDATA / HRDATA, HREADYOUT, HRESP   AHB-Lite slave
//            fr_sck, fr_ce_n, fr_dout, fr_douten, fr_din   flash reader side
//            fm_sck, fm_ce_n, fm_dout, fm_douten, fm_din   flash pad side
//            irq                           DONE interrupt (FLASH_WR_IRQ_EN)
// Macros   : FLASH_WR_IRQ_EN - adds irq port and IRQ_EN register at 0x14
// Revision : 1.0 - initial release
// ============================================================================
module ahb_flash_spi_writer
  import flash_writer_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic        fr_sck,
  input  logic        fr_ce_n,
  input  logic [3:0]  fr_dout,
  input  logic [3:0]  fr_douten,
  output logic [3:0]  fr_din,
  output logic        fm_sck,
  output logic        fm_ce_n,
  output logic [3:0]  fm_dout,
  output logic [3:0]  fm_douten,
  input  logic [3:0]  fm_din
`ifdef FLASH_WR_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic             r_aphase, r_write;
  logic [7:0]       r_addr;
  logic             r_we, r_ss, r_quad, r_rx, r_done, r_ovr;
  logic [DIV_W-1:0] r_div;

  logic       w_wr, w_data_wr, w_st_wr, w_start;
  logic       w_busy, w_eng_done, w_eng_sck;
  logic [7:0] w_rx_byte;
  logic [3:0] w_eng_dout, w_eng_douten;
  logic       w_unused;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign fr_din    = fm_din;
  assign w_unused  = ^{HADDR[31:8], HTRANS[0]};

  assign w_wr      = r_aphase & r_write;
  assign w_data_wr = w_wr & (r_addr == C_ADDR_DATA);
  assign w_st_wr   = w_wr & (r_addr == C_ADDR_STATUS);
  assign w_start   = w_data_wr & r_we & ~w_busy;

  flash_shift_engine #(.DIV_W(DIV_W)) u_engine (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .i_start   (w_start),
    .i_byte    (HWDATA[7:0]),
    .i_quad    (r_quad),
    .i_rx      (r_rx),
    .i_div     (r_div),
    .i_abort   (~r_we),
    .i_din     (fm_din),
    .o_busy    (w_busy),
    .o_done    (w_eng_done),
    .o_rx_byte (w_rx_byte),
    .o_sck     (w_eng_sck),
    .o_dout    (w_eng_dout),
    .o_douten  (w_eng_douten)
  );

`ifdef FLASH_WR_IRQ_EN
  logic r_irq_en, r_irq;
  assign irq = r_irq;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_aphase <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= 8'h00;
      r_we     <= 1'b0;
      r_ss     <= 1'b1;
      r_quad   <= 1'b0;
      r_rx     <= 1'b0;
      r_div    <= DIV_W'(DIV_RST);
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
`ifdef FLASH_WR_IRQ_EN
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
`endif
    end else begin
      if (HREADY) begin
        r_aphase <= HSEL & HTRANS[1];
        r_write  <= HWRITE;
        r_addr   <= HADDR[7:0];
      end
      if (w_wr && r_addr == C_ADDR_WE && HWDATA[31:8] == C_WE_KEY)
        r_we <= HWDATA[0];
      if (w_wr && r_addr == C_ADDR_CTRL) begin
        r_ss   <= HWDATA[C_CTRL_SS];
        r_quad <= HWDATA[C_CTRL_QUAD];
        r_rx   <= HWDATA[C_CTRL_RX];
      end
      if (w_wr && r_addr == C_ADDR_DIV)
        r_div <= HWDATA[DIV_W-1:0];
      // A finishing transfer beats a simultaneous W1C of DONE.
      if (w_eng_done)
        r_done <= 1'b1;
      else if (w_st_wr && HWDATA[C_ST_DONE])
        r_done <= 1'b0;
      if (w_data_wr && w_busy)
        r_ovr <= 1'b1;
      else if (w_st_wr && HWDATA[C_ST_OVR])
        r_ovr <= 1'b0;
`ifdef FLASH_WR_IRQ_EN
      if (w_wr && r_addr == C_ADDR_IRQ_EN)
        r_irq_en <= HWDATA[0];
      r_irq <= r_irq_en & r_done;
`endif
    end
  end

  always_comb begin
    HRDATA = 32'h0;
    if (r_aphase && !r_write) begin
      case (r_addr)
        C_ADDR_WE:     HRDATA[0] = r_we;
        C_ADDR_CTRL: begin
          HRDATA[C_CTRL_SS]   = r_ss;
          HRDATA[C_CTRL_QUAD] = r_quad;
          HRDATA[C_CTRL_RX]   = r_rx;
        end
        C_ADDR_DIV:    HRDATA = 32'(r_div);
        C_ADDR_DATA:   HRDATA[7:0] = w_rx_byte;
        C_ADDR_STATUS: begin
          HRDATA[C_ST_BUSY] = w_busy;
          HRDATA[C_ST_DONE] = r_done;
          HRDATA[C_ST_OVR]  = r_ovr;
        end
`ifdef FLASH_WR_IRQ_EN
        C_ADDR_IRQ_EN: HRDATA[0] = r_irq_en;
`endif
        default: HRDATA = 32'h0;
      endcase
    end
  end

  // Pin ownership: engine plus CTRL.SS while unlocked, flash reader otherwise.
  always_comb begin
    if (r_we) begin
      fm_sck    = w_eng_sck;
      fm_ce_n   = r_ss;
      fm_dout   = w_eng_dout;
      fm_douten = w_eng_douten;
    end else begin
      fm_sck    = fr_sck;
      fm_ce_n   = fr_ce_n;
      fm_dout   = fr_dout;
      fm_douten = fr_douten;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_flash_spi_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_flash_spi_writer
// Purpose  : Self-checking bench for ahb_flash_spi_writer. Expected lane
//            beats, input nibbles and received bytes are queued when a
//            transfer is set up and popped as the DUT produces them.
// Macros   : FLASH_WR_IRQ_EN - enables the irq scenario
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_flash_spi_writer;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [1:0]  HTRANS = 2'b00;
  logic [31:0] HADDR = 32'h0;
  logic        HWRITE = 1'b0;
  logic        HREADY = 1'b1;
  logic [31:0] HWDATA = 32'h0;
  logic [31:0] HRDATA;
  logic        HREADYOUT, HRESP;
  logic        fr_sck = 1'b0, fr_ce_n = 1'b1;
  logic [3:0]  fr_dout = 4'h0, fr_douten = 4'h0, fr_din;
  logic        fm_sck, fm_ce_n;
  logic [3:0]  fm_dout, fm_douten;
  logic [3:0]  fm_din = 4'h0;
`ifdef FLASH_WR_IRQ_EN
  logic        irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] q_beat[$];
  logic [3:0] q_din[$];
  logic [7:0] q_rx[$];

  always #5 HCLK = ~HCLK;

  ahb_flash_spi_writer #(.DIV_W(8), .DIV_RST(1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS),
    .HADDR(HADDR), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .fr_sck(fr_sck), .fr_ce_n(fr_ce_n), .fr_dout(fr_dout),
    .fr_douten(fr_douten), .fr_din(fr_din),
    .fm_sck(fm_sck), .fm_ce_n(fm_ce_n), .fm_dout(fm_dout),
    .fm_douten(fm_douten), .fm_din(fm_din)
`ifdef FLASH_WR_IRQ_EN
    , .irq(irq)
`endif
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bus tasks (entered/left 1ns after a rising edge) -------
  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, a};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'h0, a};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  // Back-to-back STATUS reads from the next cycle on until BUSY is low.
  task automatic wait_idle(output int n, output logic [31:0] st);
    bit ok = 0;
    n = 0; st = 32'h0;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h10;
    for (int g = 0; g < 4000; g++) begin
      @(posedge HCLK); #1;
      st = HRDATA;
      if (!st[0]) begin ok = 1; break; end
      n++;
    end
    HSEL = 1'b0; HTRANS = 2'b00;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL wait_idle_timeout: got busy expected idle"); end
  endtask

  // Start a transfer and, every cycle it is busy, read STATUS, drive the
  // queued input nibble and check each SCK rising edge against the queues.
  task automatic run_xfer(input logic [7:0] data, input logic quad, input logic rx,
                          input logic [3:0] exp_oe, output int busy_cycles);
    logic [31:0] st;
    logic [3:0]  mask, beat;
    logic        prev_sck;
    bit          ok;
    ahb_write(8'h10, 32'h6);
    if (!(quad && rx)) begin
      if (quad) begin q_beat.push_back(data[7:4]); q_beat.push_back(data[3:0]); end
      else for (int i = 7; i >= 0; i--) q_beat.push_back({3'b000, data[i]});
    end
    mask = quad ? 4'hF : 4'h1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0C;
    @(posedge HCLK); #1;
    HWDATA = {24'h0, data}; HWRITE = 1'b0; HADDR = 32'h10;
    @(posedge HCLK); #1;
    busy_cycles = 0; prev_sck = 1'b0; ok = 0; st = 32'h0;
    for (int g = 0; g < 4000; g++) begin
      st = HRDATA;
      if (!st[0]) begin ok = 1; break; end
      busy_cycles++;
      if (fm_sck && !prev_sck) begin
        n_tests++;
        if (fm_douten !== exp_oe) begin
          n_fail++; $display("FAIL douten: got %h expected %h", fm_douten, exp_oe);
        end
        if (q_beat.size() > 0) begin
          beat = q_beat.pop_front();
          n_tests++;
          if ((fm_dout & mask) !== beat) begin
            n_fail++; $display("FAIL dout_beat: got %h expected %h", fm_dout & mask, beat);
          end
        end
        if (q_din.size() > 0) void'(q_din.pop_front());
      end
      if (!fm_sck && q_din.size() > 0) fm_din = q_din[0];
      prev_sck = fm_sck;
      @(posedge HCLK); #1;
    end
    HSEL = 1'b0; HTRANS = 2'b00;
    n_tests++;
    if (!ok || st[1] !== 1'b1) begin
      n_fail++; $display("FAIL done_at_busy_fall: got status %h expected done=1 busy=0", st[2:0]);
    end
    n_tests++;
    if (q_beat.size() != 0) begin
      n_fail++; $display("FAIL sck_pulse_count: got %0d beats left expected 0", q_beat.size());
      q_beat.delete();
    end
  endtask

  task automatic check_rx(input string name);
    logic [31:0] d;
    logic [7:0]  e;
    ahb_read(8'h0C, d);
    e = (q_rx.size() > 0) ? q_rx.pop_front() : 8'hxx;
    n_tests++;
    if (d !== {24'h0, e}) begin
      n_fail++; $display("FAIL %s: got %h expected %h", name, d, e);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    logic [7:0]  addrs[5];
    logic [31:0] exps[5];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};
    exps  = '{32'h0, 32'h1, 32'h1, 32'h0, 32'h0};
    fr_sck = 1'b1; fr_ce_n = 1'b0; fr_dout = 4'h9; fr_douten = 4'h6; fm_din = 4'h7;
    repeat (3) @(posedge HCLK); #1;
    n_tests++;
    if ({fm_sck, fm_ce_n, fm_dout, fm_douten} !== {1'b1, 1'b0, 4'h9, 4'h6}) begin
      n_fail++;
      $display("FAIL reset_passthrough: got %b expected %b",
               {fm_sck, fm_ce_n, fm_dout, fm_douten}, {1'b1, 1'b0, 4'h9, 4'h6});
    end
    n_tests++;
    if (fr_din !== 4'h7) begin n_fail++; $display("FAIL fr_din: got %h expected 7", fr_din); end
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    foreach (addrs[i]) begin
      ahb_read(addrs[i], d);
      n_tests++;
      if (d !== exps[i]) begin
        n_fail++; $display("FAIL reset_reg_%h: got %h expected %h", addrs[i], d, exps[i]);
      end
    end
`ifdef FLASH_WR_IRQ_EN
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
`endif
  endtask

  task automatic test_we_key();
    logic [31:0] d;
    ahb_write(8'h00, 32'h0000_0001);
    ahb_read(8'h00, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL we_bad_key: got %h expected 0", d); end
    n_tests++;
    if (fm_sck !== 1'b1) begin n_fail++; $display("FAIL we_bad_key_sck: got %b expected 1", fm_sck); end
    ahb_write(8'h00, 32'hA5A8_5501);
    ahb_read(8'h00, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL we_good_key: got %h expected 1", d); end
    n_tests++;
    if ({fm_sck, fm_ce_n, fm_douten} !== {1'b0, 1'b1, 4'h0}) begin
      n_fail++; $display("FAIL we_engine_pins: got %b expected %b",
                         {fm_sck, fm_ce_n, fm_douten}, {1'b0, 1'b1, 4'h0});
    end
  endtask

  task automatic test_single();
    int bc;
    logic [7:0] rxb;
    rxb = 8'h96;
    ahb_write(8'h08, 32'h0);
    ahb_write(8'h04, 32'h0);
    n_tests++;
    if (fm_ce_n !== 1'b0) begin n_fail++; $display("FAIL ss_low: got %b expected 0", fm_ce_n); end
    for (int i = 7; i >= 0; i--) q_din.push_back({2'b00, rxb[i], 1'b0});
    q_rx.push_back(rxb);
    run_xfer(8'hA5, 1'b0, 1'b0, 4'b0001, bc);
    n_tests++;
    if (bc != 16) begin n_fail++; $display("FAIL single_busy_len: got %0d expected 16", bc); end
    check_rx("single_rx");
  endtask

  task automatic test_quad_rx();
    int bc;
    ahb_write(8'h08, 32'h2);
    ahb_write(8'h04, 32'h6);
    q_din.push_back(4'h3); q_din.push_back(4'hC);
    q_rx.push_back(8'h3C);
    run_xfer(8'h00, 1'b1, 1'b1, 4'b0000, bc);
    n_tests++;
    if (bc != 12) begin n_fail++; $display("FAIL quad_rx_busy_len: got %0d expected 12", bc); end
    check_rx("quad_rx_data");
  endtask

  task automatic test_quad_tx();
    int bc;
    ahb_write(8'h08, 32'h1);
    ahb_write(8'h04, 32'h2);
    q_din.push_back(4'hA); q_din.push_back(4'h5);
    q_rx.push_back(8'hA5);
    run_xfer(8'h5E, 1'b1, 1'b0, 4'b1111, bc);
    n_tests++;
    if (bc != 8) begin n_fail++; $display("FAIL quad_tx_busy_len: got %0d expected 8", bc); end
    check_rx("quad_tx_rx");
  endtask

  task automatic test_ovr();
    int n;
    logic [31:0] st, d;
    ahb_write(8'h08, 32'h0);
    ahb_write(8'h04, 32'h0);
    ahb_write(8'h10, 32'h6);
    fm_din = 4'b0010;
    q_rx.push_back(8'hFF);
    ahb_write(8'h0C, 32'hC3);   // busy from this cycle (C0)
    ahb_write(8'h0C, 32'h00);   // lands while busy; BUSY seen from C3 by wait_idle
    wait_idle(n, st);
    n_tests++;
    if (n != 13) begin n_fail++; $display("FAIL ovr_xfer_len: got %0d expected 13", n); end
    n_tests++;
    if (st[2:0] !== 3'b110) begin n_fail++; $display("FAIL ovr_status: got %b expected 110", st[2:0]); end
    check_rx("ovr_rx");
    ahb_write(8'h10, 32'h6);
    ahb_read(8'h10, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_status: got %h expected 0", d); end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    ahb_write(8'h08, 32'h1);
    fm_din = 4'h0;
    fr_sck = 1'b1; fr_ce_n = 1'b1; fr_dout = 4'h5; fr_douten = 4'hA;
    ahb_write(8'h0C, 32'hFF);
    repeat (5) @(posedge HCLK);
    #1;
    ahb_write(8'h00, 32'hA5A8_5500);
    n_tests++;
    if ({fm_sck, fm_ce_n, fm_dout, fm_douten} !== {1'b1, 1'b1, 4'h5, 4'hA}) begin
      n_fail++; $display("FAIL abort_passthrough: got %b expected %b",
                         {fm_sck, fm_ce_n, fm_dout, fm_douten}, {1'b1, 1'b1, 4'h5, 4'hA});
    end
    ahb_read(8'h10, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL abort_status: got %h expected 0", d); end
    q_rx.push_back(8'hFF);
    check_rx("abort_rx_kept");
    ahb_write(8'h00, 32'hA5A8_5501);
    n_tests++;
    if ({fm_sck, fm_dout, fm_douten} !== 9'h0) begin
      n_fail++; $display("FAIL abort_engine_idle: got %b expected 0", {fm_sck, fm_dout, fm_douten});
    end
  endtask

`ifdef FLASH_WR_IRQ_EN
  task automatic test_irq();
    int n;
    logic [31:0] st, d;
    ahb_write(8'h14, 32'h1);
    ahb_read(8'h14, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL irq_en_reg: got %h expected 1", d); end
    ahb_write(8'h08, 32'h0);
    ahb_write(8'h04, 32'h2);
    ahb_write(8'h10, 32'h6);
    ahb_write(8'h0C, 32'h11);
    wait_idle(n, st);
    n_tests++;
    if (st[1] !== 1'b1 || irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_with_done: got done=%b irq=%b expected done=1 irq=0", st[1], irq);
    end
    @(posedge HCLK); #1;
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b expected 1", irq); end
    ahb_write(8'h10, 32'h2);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold: got %b expected 1", irq); end
    @(posedge HCLK); #1;
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b expected 0", irq); end
  endtask
`else
  task automatic test_irq();
    logic [31:0] d;
    ahb_write(8'h14, 32'h1);
    ahb_read(8'h14, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL irq_en_absent: got %h expected 0", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_we_key();
    test_single();
    test_quad_rx();
    test_quad_tx();
    test_ovr();
    test_abort();
    test_irq();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
